// File: rtl/conv_pkg.sv
// Shared state encoding, sizing helpers and pipeline latency for the systolic
// convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  // Window register -> product register -> sum register.
  localparam int CONV_LAT = 3;

  function automatic int acc_w(input int data_size, input int k);
    return 2 * data_size + 1 + $clog2(k * k);
  endfunction

  function automatic int wa_w(input int n, input int k);
    return $clog2(n * k * k);
  endfunction

endpackage

// File: rtl/conv_window_gen.sv
// Raster-order window generator: K-1 line buffers, a KxK window shift array and
// row/col counters that advance only on accepted pixels.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int DATA_SIZE   = 8,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              pix_valid_i,
  input  logic [DATA_SIZE-1:0]                              pix_i,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]      window_o,
  output logic                                              window_valid_o
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic                 window_valid_q;
  // lb_q[m] holds the row m+1 above the one currently streaming in.
  logic [DATA_SIZE-1:0] lb_q [K-1][IMG_WIDTH];
  // col_pix[m] is the pixel m rows above the incoming one, same column.
  logic [DATA_SIZE-1:0] col_pix [K];

  always_comb begin
    col_pix[0] = pix_i;
    for (int m = 1; m < K; m++) begin
      col_pix[m] = lb_q[m-1][col_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < K - 1; m++) begin
        for (int c = 0; c < IMG_WIDTH; c++) begin
          lb_q[m][c] <= '0;
        end
      end
    end else if (pix_valid_i) begin
      lb_q[0][col_q] <= pix_i;
      for (int m = 1; m < K - 1; m++) begin
        lb_q[m][col_q] <= lb_q[m-1][col_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
    end else begin
      window_valid_q <= pix_valid_i && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
      if (pix_valid_i) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      logic [DATA_SIZE-1:0] tap_q [K];

      // Window row gi is image row r-K+1+gi, i.e. K-1-gi rows above the input.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < K; j++) begin
            tap_q[j] <= '0;
          end
        end else if (pix_valid_i) begin
          for (int j = 0; j < K - 1; j++) begin
            tap_q[j] <= tap_q[j+1];
          end
          tap_q[K-1] <= col_pix[K-1-gi];
        end
      end

      for (gj = 0; gj < K; gj++) begin : g_col
        assign window_o[(gi*K+gj)*DATA_SIZE +: DATA_SIZE] = tap_q[gj];
      end
    end
  endgenerate

  assign window_valid_o = window_valid_q;

endmodule

// File: rtl/systolic_conv_engine.sv
// Multi-kernel KxK valid-window convolution engine: FSM, weight store and MAC pipeline.
// Optional build macro SYSCONV_RELU_EN clamps negative sums to zero in the sum stage.
module systolic_conv_engine
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int DATA_SIZE   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 2,
  localparam int ACC_W      = acc_w(DATA_SIZE, KERNEL_SIZE),
  localparam int WA_W       = wa_w(NUM_KERNELS, KERNEL_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         k_wr_en,
  input  logic [WA_W-1:0]              k_wr_addr,
  input  logic [DATA_SIZE-1:0]         k_wr_data,
  input  logic                         start,
  input  logic [DATA_SIZE-1:0]         data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [NUM_KERNELS*ACC_W-1:0] data_out,
  output logic                         data_out_valid,
  output logic                         busy,
  output logic                         img_done
);

  localparam int K    = KERNEL_SIZE;
  localparam int KK   = K * K;
  localparam int NW   = NUM_KERNELS * KK;
  localparam int PW   = 2 * DATA_SIZE + 1;
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW  = $clog2(NPIX);
  localparam logic [PCW-1:0]  PIX_LAST   = PCW'(NPIX - 1);
  localparam logic [1:0]      DRAIN_LAST = 2'(CONV_LAT - 1);
  localparam logic [WA_W:0]   NW_L       = (WA_W + 1)'(NW);

  conv_state_e    state_q;
  logic [PCW-1:0] pix_cnt_q;
  logic [1:0]     drain_cnt_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
  logic           accept;

  assign accept = data_in_valid && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            pix_cnt_q <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (pix_cnt_q == PIX_LAST) begin
              state_q     <= DRAIN;
              ready_q     <= 1'b0;
              pix_cnt_q   <= '0;
              drain_cnt_q <= '0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leaves once the last window has cleared the product and sum stages.
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_in_ready = ready_q;
  assign busy          = busy_q;
  assign img_done      = done_q;

  logic signed [DATA_SIZE-1:0] w_q [NW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < NW; a++) begin
        w_q[a] <= '0;
      end
    end else if (k_wr_en && (state_q == IDLE) && ({1'b0, k_wr_addr} < NW_L)) begin
      w_q[k_wr_addr] <= k_wr_data;
    end
  end

  logic [KK*DATA_SIZE-1:0] window;
  logic                    win_vld;
  logic                    prod_vld_q;
  logic                    sum_vld_q;

  conv_window_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .DATA_SIZE  (DATA_SIZE),
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_window_gen (
    .clk           (clk),
    .rst           (rst),
    .pix_valid_i   (accept),
    .pix_i         (data_in),
    .window_o      (window),
    .window_valid_o(win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_vld_q <= 1'b0;
      sum_vld_q  <= 1'b0;
    end else begin
      prod_vld_q <= win_vld;
      sum_vld_q  <= prod_vld_q;
    end
  end

  assign data_out_valid = sum_vld_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KERNELS; gi++) begin : g_kernel
      logic signed [PW-1:0]    prod_q [KK];
      logic signed [ACC_W-1:0] sum_d;
      logic signed [ACC_W-1:0] sum_q;

      // Pixels are unsigned, so a zero MSB makes them safe signed operands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int t = 0; t < KK; t++) begin
            prod_q[t] <= '0;
          end
        end else if (win_vld) begin
          for (int t = 0; t < KK; t++) begin
            prod_q[t] <= $signed({1'b0, window[t*DATA_SIZE +: DATA_SIZE]}) * w_q[gi*KK + t];
          end
        end
      end

      always_comb begin
        sum_d = '0;
        for (int t = 0; t < KK; t++) begin
          sum_d = sum_d + {{(ACC_W-PW){prod_q[t][PW-1]}}, prod_q[t]};
        end
`ifdef SYSCONV_RELU_EN
        if (sum_d[ACC_W-1]) begin
          sum_d = '0;
        end
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q <= '0;
        end else if (prod_vld_q) begin
          sum_q <= sum_d;
        end
      end

      assign data_out[gi*ACC_W +: ACC_W] = sum_q;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_conv_engine.sv
// Self-checking bench: a small 3x3/K=2 engine for table vectors and a default
// 8x8/K=3 engine for extreme and randomized frames against a reference model.
module tb_systolic_conv_engine;

  localparam int AW_A = 19;
  localparam int AW_B = 21;
`ifdef SYSCONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef longint lq_t[$];
  typedef struct {
    int     win;
    longint k0;
    longint k1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen_a, wen_b, start_a, start_b;
  logic [2:0]  addr_a;
  logic [4:0]  addr_b;
  logic [7:0]  k_wr_data, data_in;
  logic        data_in_valid;
  logic        rdy_a, rdy_b, vld_a, vld_b, busy_a, busy_b, done_a, done_b;
  logic [2*AW_A-1:0] dout_a;
  logic [2*AW_B-1:0] dout_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int last_vld_a = 0, last_vld_b = 0, done_cyc_a = 0, done_cyc_b = 0;
  longint q_a[$];
  longint q_b[$];
  logic signed [AW_A-1:0] sa;
  logic signed [AW_B-1:0] sb;

  int   wt_a [8];
  int   wt_b [18];
  int   pix_a [9];
  int   pix_b [64];
  vec_t tab [4];

  always #5 clk = ~clk;

  systolic_conv_engine #(
    .IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_SIZE(8), .KERNEL_SIZE(2), .NUM_KERNELS(2)
  ) dut_a (
    .clk(clk), .rst(rst), .k_wr_en(wen_a), .k_wr_addr(addr_a), .k_wr_data(k_wr_data),
    .start(start_a), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(rdy_a), .data_out(dout_a), .data_out_valid(vld_a),
    .busy(busy_a), .img_done(done_a)
  );

  systolic_conv_engine #(
    .IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_SIZE(8), .KERNEL_SIZE(3), .NUM_KERNELS(2)
  ) dut_b (
    .clk(clk), .rst(rst), .k_wr_en(wen_b), .k_wr_addr(addr_b), .k_wr_data(k_wr_data),
    .start(start_b), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(rdy_b), .data_out(dout_b), .data_out_valid(vld_b),
    .busy(busy_b), .img_done(done_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld_a) begin
      for (int k = 0; k < 2; k++) begin
        sa = dout_a[k*AW_A +: AW_A];
        q_a.push_back(longint'(sa));
      end
      last_vld_a = cyc;
    end
    if (vld_b) begin
      for (int k = 0; k < 2; k++) begin
        sb = dout_b[k*AW_B +: AW_B];
        q_b.push_back(longint'(sb));
      end
      last_vld_b = cyc;
    end
    if (done_a) begin
      done_cnt_a = done_cnt_a + 1;
      done_cyc_a = cyc;
    end
    if (done_b) begin
      done_cnt_b = done_cnt_b + 1;
      done_cyc_b = cyc;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Valid-window convolution straight from the definition.
  function automatic lq_t model(input int sel);
    lq_t    q;
    int     w, h, k;
    int     p[$];
    int     wt[$];
    longint s;
    if (sel == 0) begin
      w = 3; h = 3; k = 2;
      foreach (pix_a[i]) p.push_back(pix_a[i]);
      foreach (wt_a[i]) wt.push_back(wt_a[i]);
    end else begin
      w = 8; h = 8; k = 3;
      foreach (pix_b[i]) p.push_back(pix_b[i]);
      foreach (wt_b[i]) wt.push_back(wt_b[i]);
    end
    for (int r = k - 1; r < h; r++) begin
      for (int c = k - 1; c < w; c++) begin
        for (int n = 0; n < 2; n++) begin
          s = 0;
          for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
              s += longint'(p[(r-k+1+i)*w + (c-k+1+j)]) * longint'(wt[n*k*k + i*k + j]);
            end
          end
          if (RELU && s < 0) s = 0;
          q.push_back(s);
        end
      end
    end
    return q;
  endfunction

  task automatic load_weights(input int sel);
    int n;
    n = (sel == 0) ? 8 : 18;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) begin
        wen_a = 1'b1; addr_a = 3'(i); k_wr_data = 8'(wt_a[i]);
      end else begin
        wen_b = 1'b1; addr_b = 5'(i); k_wr_data = 8'(wt_b[i]);
      end
    end
    @(negedge clk);
    wen_a = 1'b0;
    wen_b = 1'b0;
  endtask

  // mode 0: contiguous, 1: valid every other cycle, 2: random gaps.
  // inject: attempt a weight write and a start while the frame is running.
  task automatic run_frame(input int sel, input int mode, input bit inject);
    int idx, n, guard;
    bit v, rd;
    n = (sel == 0) ? 9 : 64;
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 4000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      data_in_valid = v;
      data_in = 8'((sel == 0) ? pix_a[idx] : pix_b[idx]);
      if (inject && idx == 3) begin
        wen_a = 1'b1; addr_a = 3'd0; k_wr_data = 8'd77; start_a = 1'b1;
      end else begin
        wen_a = 1'b0; start_a = 1'b0;
      end
      rd = (sel == 0) ? rdy_a : rdy_b;
      @(negedge clk);
      if (v && rd) idx++;
      guard++;
    end
    data_in_valid = 1'b0;
    wen_a = 1'b0;
    start_a = 1'b0;
    check("pixels_accepted", idx, n);
  endtask

  task automatic wait_done(input int sel, input int prev);
    int  n;
    bit  seen;
    seen = 1'b0;
    n = prev;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      n = (sel == 0) ? done_cnt_a : done_cnt_b;
      if (n > prev) seen = 1'b1;
    end
    check("img_done_seen", seen, 1);
    if (sel == 0) check("done_after_last_valid", done_cyc_a - last_vld_a, 1);
    else          check("done_after_last_valid", done_cyc_b - last_vld_b, 1);
  endtask

  task automatic frame_table(input string name, input int mode, input bit inject);
    int prev;
    q_a.delete();
    prev = done_cnt_a;
    run_frame(0, mode, inject);
    wait_done(0, prev);
    repeat (3) @(negedge clk);
    check({name, "_count"}, q_a.size(), 8);
    check({name, "_frames"}, done_cnt_a - prev, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_w%0d_k0", name, tab[i].win), q_a[2*i], tab[i].k0);
      check($sformatf("%s_w%0d_k1", name, tab[i].win), q_a[2*i+1], tab[i].k1);
    end
  endtask

  task automatic frame_model(input string name, input int mode);
    int  prev;
    lq_t exp;
    exp = model(1);
    q_b.delete();
    prev = done_cnt_b;
    run_frame(1, mode, 1'b0);
    wait_done(1, prev);
    check({name, "_count"}, q_b.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_b.size(); i++) begin
      if (q_b[i] != exp[i] || i < 2) begin
        check($sformatf("%s_r%0d", name, i), q_b[i], exp[i]);
      end else begin
        tests++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint k1e;
    int     prev;
    lq_t    zq;
    wen_a = 0; wen_b = 0; start_a = 0; start_b = 0;
    addr_a = '0; addr_b = '0; k_wr_data = '0; data_in = '0; data_in_valid = 0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dout_a", dout_a, 0);
    check("rst_valid_a", vld_a, 0);
    check("rst_ready_a", rdy_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_dout_b", dout_b, 0);
    rst = 1'b0;

    wt_a = '{1, 1, 1, 1, 1, 0, 0, -1};
    for (int i = 0; i < 9; i++) pix_a[i] = i + 1;
    k1e = RELU ? 0 : -4;
    tab[0] = '{0, 12, k1e};
    tab[1] = '{1, 16, k1e};
    tab[2] = '{2, 24, k1e};
    tab[3] = '{3, 28, k1e};
    load_weights(0);

    frame_table("basic", 0, 1'b0);
    sa = dout_a[AW_A-1:0];
    check("hold_dout_k0", longint'(sa), 28);
    check("hold_valid_low", vld_a, 0);
    frame_table("stall", 1, 1'b0);
    frame_table("repeat", 0, 1'b0);
    frame_table("ignored_wr_start", 0, 1'b1);
    repeat (3) @(negedge clk);
    check("idle_after_ignored_start", busy_a, 0);

    // Extreme values: full-scale pixels against the most negative weight.
    for (int i = 0; i < 9; i++) wt_b[i] = -128;
    for (int i = 9; i < 18; i++) wt_b[i] = 1;
    for (int i = 0; i < 64; i++) pix_b[i] = 255;
    load_weights(1);
    frame_model("extreme", 0);
    check("extreme_first_k0", q_b[0], RELU ? 0 : -293760);
    check("extreme_first_k1", q_b[1], 2295);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 18; i++) wt_b[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 64; i++) pix_b[i] = int'($urandom_range(0, 255));
      load_weights(1);
      frame_model($sformatf("random%0d", f), 2);
    end

    // Reset while pixel 5 of a frame is on the bus.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in_valid = 1'b1;
      data_in = 8'(i + 1);
      @(negedge clk);
    end
    data_in = 8'd5;
    #2 rst = 1'b1;
    #1;
    check("midrst_dout_a", dout_a, 0);
    check("midrst_valid_a", vld_a, 0);
    check("midrst_ready_a", rdy_a, 0);
    check("midrst_busy_a", busy_a, 0);
    check("midrst_done_a", done_a, 0);
    check("midrst_dout_b", dout_b, 0);
    data_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Weights were cleared, so an unreloaded frame yields all zeros.
    q_a.delete();
    prev = done_cnt_a;
    run_frame(0, 0, 1'b0);
    wait_done(0, prev);
    repeat (3) @(negedge clk);
    check("zero_w_count", q_a.size(), 8);
    zq = q_a;
    for (int i = 0; i < zq.size(); i++) check($sformatf("zero_w_r%0d", i), zq[i], 0);

    load_weights(0);
    frame_table("after_reset", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
